// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - classifies counter value changes into buffered event records
//
// Purpose: samples an upstream 8-bit counter every cycle, classifies each change
// as WRAP, CLEAR, THRESH or JUMP, and queues the records in a DEPTH-entry FIFO
// presented on a valid/ready output. Drops on a full FIFO are flagged.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   count[7:0]          counter value from the upstream stage
//   threshold[7:0]      compare value for THRESH events
//   thresh_en           enables THRESH events
//   ovf_clr             synchronous clear of overflow/drop_cnt
//   evt_valid/evt_ready head handshake
//   evt_code[1:0]       head type: 00 JUMP, 01 WRAP, 10 THRESH, 11 CLEAR
//   evt_value[7:0]      head payload
//   overflow            sticky drop flag
//   drop_cnt[7:0]       saturating drop count
module count_event_monitor #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  input  logic [7:0] threshold,
  input  logic       thresh_en,
  input  logic       ovf_clr,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic [7:0] evt_value,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] CODE_JUMP   = 2'b00;
  localparam logic [1:0] CODE_WRAP   = 2'b01;
  localparam logic [1:0] CODE_THRESH = 2'b10;
  localparam logic [1:0] CODE_CLEAR  = 2'b11;

  logic [7:0]  prev_q;
  logic        prev_vld_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [9:0]  mem_q [DEPTH];
  logic        evt_valid_q, evt_valid_d;
  logic [9:0]  head_q, head_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        det;
  logic [1:0]  det_code;
  logic [7:0]  det_value;
  logic        full, pop, push, drop;

  // Event classification in fixed priority order; a plain +1 step is silent.
  always_comb begin
    det       = 1'b0;
    det_code  = CODE_JUMP;
    det_value = count;
    if (prev_vld_q && (count != prev_q)) begin
      det = 1'b1;
      if ((prev_q == 8'hFF) && (count == 8'h00)) begin
        det_code  = CODE_WRAP;
        det_value = 8'h00;
      end else if (count == 8'h00) begin
        det_code  = CODE_CLEAR;
        det_value = prev_q;
      end else if (thresh_en && (count == threshold)) begin
        det_code  = CODE_THRESH;
      end else if (count == prev_q + 8'd1) begin
        det = 1'b0;
      end
    end
  end

  // Full when the extra pointer bit differs and the index bits match.
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop  = evt_valid_q && evt_ready;
  assign push = det && (!full || pop);
  assign drop = det && full && !pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    evt_valid_d = (wr_ptr_d != rd_ptr_d);
    // The head register tracks the entry that will sit at rd_ptr_d; when the
    // queue drains to empty and refills this edge, that entry is the new push.
    if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head_d = {det_code, det_value};
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= 8'd0;
      prev_vld_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      head_q      <= 10'd0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      prev_q      <= count;
      prev_vld_q  <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      evt_valid_q <= evt_valid_d;
      head_q      <= head_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {det_code, det_value};
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = head_q[9:8];
  assign evt_value = head_q[7:0];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
